// File: rtl/freq_div_n.sv
// Runtime-programmable integer clock divider: registered clk_out (high ceil(N/2)),
// a tick at each period start, and divisor changes deferred to period boundaries.
module freq_div_n #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             n_rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_cur,
   output logic             upd_pend,
   output logic             load_err
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             upd_pend_q, upd_pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             load_err_q, load_err_d;
   logic             wrap;
   logic [CNT_W:0]   half;

   assign wrap = (cnt_q == (div_cur_q - ONE));
   // High time uses the divisor in effect after this edge; one extra bit avoids overflow.
   assign half = ({1'b0, div_cur_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

   always_comb begin
      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      pend_d     = pend_q;
      upd_pend_d = upd_pend_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;
      load_err_d = 1'b0;

      if (en) begin
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (upd_pend_q) begin
               div_cur_d  = pend_q;
               upd_pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
         clk_out_d = ({1'b0, cnt_d} < half);
      end

      // A load on a wrap edge is applied after the wrap consumed the old pending value.
      if (div_load) begin
         if (div_in >= TWO) begin
            pend_d     = div_in;
            upd_pend_d = 1'b1;
         end else begin
            load_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!n_rst) begin
         cnt_q      <= DEF_DIV - ONE;
         div_cur_q  <= DEF_DIV;
         pend_q     <= DEF_DIV;
         upd_pend_q <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         pend_q     <= pend_d;
         upd_pend_q <= upd_pend_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         load_err_q <= load_err_d;
      end
   end

   assign clk_out  = clk_out_q;
   assign tick     = tick_q;
   assign div_cur  = div_cur_q;
   assign upd_pend = upd_pend_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_freq_div_n.sv
// Bench for freq_div_n: directed scenarios plus random traffic, all checked
// against a period-level reference model (remaining cycles / position in period).
module tb_freq_div_n;

   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 2;

   logic             clk_in = 1'b0;
   logic             n_rst;
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             clk_out;
   logic             tick;
   logic [CNT_W-1:0] div_cur;
   logic             upd_pend;
   logic             load_err;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Reference model state: divisor in effect, pending divisor, position in period.
   int m_n, m_pend, m_pos, m_rem;
   bit m_pv, m_clk, m_tick, m_err;
   int tick_total;

   freq_div_n #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clk_in   (clk_in),
      .n_rst    (n_rst),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .clk_out  (clk_out),
      .tick     (tick),
      .div_cur  (div_cur),
      .upd_pend (upd_pend),
      .load_err (load_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input int obs, input int exp);
      chk_cnt++;
      if (obs != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit ld, input int d);
      if (!r) begin
         m_n = DEFAULT_DIV; m_pend = DEFAULT_DIV; m_pv = 0;
         m_rem = 0; m_pos = 0; m_clk = 0; m_tick = 0; m_err = 0;
         return;
      end
      if (e) begin
         if (m_rem == 0) begin
            if (m_pv) begin
               m_n = m_pend;
               m_pv = 0;
            end
            m_tick = 1; m_pos = 0; m_rem = m_n - 1;
         end else begin
            m_tick = 0; m_pos++; m_rem--;
         end
         m_clk = (m_pos < (m_n + 1) / 2);
      end else begin
         m_tick = 0;
      end
      if (ld) begin
         if (d >= 2) begin
            m_pend = d; m_pv = 1; m_err = 0;
         end else begin
            m_err = 1;
         end
      end else begin
         m_err = 0;
      end
   endtask

   // One clk_in cycle: drive, clock, update model, compare every output.
   task automatic step(input bit r, input bit e, input bit ld, input int d);
      n_rst    = r;
      en       = e;
      div_load = ld;
      div_in   = CNT_W'(d);
      @(posedge clk_in);
      model_edge(r, e, ld, d);
      #1;
      check("clk_out",  int'(clk_out),  int'(m_clk));
      check("tick",     int'(tick),     int'(m_tick));
      check("div_cur",  int'(div_cur),  m_n);
      check("upd_pend", int'(upd_pend), int'(m_pv));
      check("load_err", int'(load_err), int'(m_err));
      if (tick) tick_total++;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 1, 0, 0);
   endtask

   initial begin
      int guard;
      n_rst = 0; en = 0; div_load = 0; div_in = '0;
      m_n = DEFAULT_DIV; m_pend = DEFAULT_DIV; m_pv = 0; m_rem = 0; m_pos = 0;
      m_clk = 0; m_tick = 0; m_err = 0;
      tick_total = 0;

      // Reset, with a load in the same cycle that must be ignored
      step(0, 1, 1, 7);
      step(0, 0, 0, 0);

      // Default N=2: 32 edges give 16 ticks
      tick_total = 0;
      run(32);
      check("ticks_n2", tick_total, 16);

      // Load 5 mid-period
      step(1, 1, 1, 5);
      run(22);

      // 3 then 7 before one boundary
      step(1, 1, 1, 3);
      step(1, 1, 1, 7);
      run(20);

      // Load 6 exactly on a wrap edge
      guard = 0;
      while (m_rem != 0 && guard < 20) begin
         run(1);
         guard++;
      end
      check("wrap_found", int'(m_rem == 0), 1);
      step(1, 1, 1, 6);
      run(20);

      // Illegal loads
      step(1, 1, 1, 0);
      step(1, 1, 1, 1);
      run(12);

      // N=4, freeze during high phase
      step(1, 1, 1, 4);
      guard = 0;
      while (!(m_n == 4 && m_pos == 0) && guard < 20) begin
         run(1);
         guard++;
      end
      check("n4_start", int'(m_n == 4 && m_pos == 0), 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      run(12);

      // N=9 with 2 pending, then reset
      step(1, 1, 1, 9);
      run(12);
      step(1, 1, 1, 2);
      run(3);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      check("post_rst_tick", int'(tick), 1);
      run(8);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         bit r, e, ld;
         int d;
         r  = ($urandom_range(0, 199) != 0);
         e  = ($urandom_range(0, 9) < 8);
         ld = ($urandom_range(0, 19) == 0);
         d  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                           : int'($urandom_range(0, 12));
         step(r, e, ld, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/freq_div_n.md
Name: freq_div_n

Overview:
Parametrised, runtime-programmable integer clock divider. It is the successor to the fixed divide-by-2 block. It divides clk_in by any N in 2..2^CNT_W-1. Outputs are a registered clk_out with high time ceil(N/2) and a one-cycle tick aligned to each clk_out rising edge. Divisor changes are glitch-free: they take effect only at a period boundary. The block feeds slow-clock enables and bit-rate generators elsewhere in the design.

Parameters:
CNT_W, 8, width of the divisor and the internal period counter.
DEFAULT_DIV, 2, divisor in effect after reset; must be in 2..2^CNT_W-1.

Ports:
clk_in  input  1  clock; all logic on its rising edge.
n_rst  input  1  reset, synchronous, active-low.
en  input  1  count enable; low freezes counter and outputs.
div_in  input  CNT_W  requested divisor N.
div_load  input  1  single-cycle strobe; captures div_in.
clk_out  output  1  divided clock, registered.
tick  output  1  one-cycle pulse in the first clk_in cycle of each output period.
div_cur  output  CNT_W  divisor currently in effect.
upd_pend  output  1  a loaded divisor is waiting for the next period boundary.
load_err  output  1  one-cycle pulse: div_load carried an illegal value (0 or 1).

Behaviour:
- Reset (n_rst=0 at rising edge):
  - Registers: cnt=DEFAULT_DIV-1, div_cur=DEFAULT_DIV, pending register=DEFAULT_DIV.
  - Outputs: upd_pend=0, clk_out=0, tick=0, load_err=0.
  - A div_load in the same cycle is ignored.
- Reset mid-operation discards any pending divisor and restarts cleanly. The next enabled edge is a period start.
- Counting at each edge with n_rst=1 and en=1:
  - If cnt==div_cur-1 (wrap): cnt<=0; tick<=1.
    - If upd_pend=1: div_cur<=pending and upd_pend<=0.
  - Otherwise: cnt<=cnt+1; tick<=0.
- clk_out<=1 when the next cnt < H, else 0.
  - H=ceil(D/2), where D is the divisor in effect after this edge.
  - Result: period N cycles, high ceil(N/2), low floor(N/2). N=2 toggles every edge; N=3 gives 2 high/1 low; N=5 gives 3/2.
- First enabled edge after reset is a wrap. clk_out rises and tick pulses together.
- en=0:
  - cnt, div_cur and clk_out hold.
  - tick<=0.
  - div_load still captures.
- Divisor load (div_load=1, n_rst=1):
  - If div_in>=2: pending<=div_in; upd_pend<=1; load_err<=0.
  - If div_in<2: pending and upd_pend unchanged; load_err<=1 for one cycle.
  - With no div_load, load_err<=0.
- Multiple legal loads before a boundary: the last one wins.
- Load on the same edge as a wrap: the wrap uses the pending value held before that edge. The new value becomes pending and applies at the following wrap.
- Loading a value equal to div_cur is legal. It sets upd_pend and is consumed at the next wrap with no visible change.
- No output glitches: clk_out is a flop output. The first period after a divisor switch has exactly the new shape.
- Counter width: cnt is CNT_W bits. Since N <= 2^CNT_W-1, cnt never overflows.

Test Plan:
- Reset, en=1, default N=2 → clk_out 1,0,1,0… toggling every clk_in edge; tick high on every 1-cycle; div_cur=2; 32 edges give 16 ticks.
- Load div_in=5 mid-period → upd_pend=1 until next wrap; from that wrap clk_out is 3 high/2 low repeating, ticks every 5 cycles; div_cur=5; the old period is never truncated.
- Load 3 then 7 before one boundary → only 7 applied (4 high/3 low). Load 6 on the exact wrap edge → current wrap keeps the old value; 6 applies one period later.
- div_load with div_in=0 and then 1 → load_err pulses one cycle each; upd_pend and div_cur unchanged; waveform undisturbed.
- N=4 running, en low for 5 cycles mid-high-phase → clk_out and cnt frozen, tick=0; on resume the period completes with the exact remaining count (total high time 2 enabled cycles).
- N=9 with load of 2 pending, assert n_rst=0 for one edge → all registers at reset values, upd_pend=0; the next enabled edge gives clk_out=1 and tick=1 at N=DEFAULT_DIV.
